mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_pkg.sv | 55 +++++
 rtl/alu_decode.sv | 25 ++
 rtl/mc_control.sv | 210 +++++++++++++++++++++
 tb/tb_mc_control.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, functs,
// ALU control codes, mux selects and trap causes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

endpackage

// File: rtl/alu_decode.sv
// Combinational R-type funct decoder: ALU control code plus a valid flag so
// the controller can trap on unsupported functs.
module alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctrl,
  output logic       o_funct_valid
);

  always_comb begin
    o_alu_ctrl    = ALU_AND;
    o_funct_valid = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_ctrl = ALU_ADD;
      FN_SUB:  o_alu_ctrl = ALU_SUB;
      FN_AND:  o_alu_ctrl = ALU_AND;
      FN_OR:   o_alu_ctrl = ALU_OR;
      FN_SLT:  o_alu_ctrl = ALU_SLT;
      FN_SLL:  o_alu_ctrl = ALU_SLL;
      default: o_funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-style control FSM with a memory-wait watchdog and a sticky
// trap state that only reset leaves.
module mc_control
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] alu_ctrl,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  // The WAIT_MAX-th consecutive not-ready cycle is the one that traps.
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wait_cnt;
  logic [1:0]    r_trap_cause;
  logic [1:0]    w_cause;
  logic          w_wait_hit;
  logic [3:0]    w_alu_funct;
  logic          w_funct_valid;

  alu_decode u_alu_decode (
    .i_funct      (funct),
    .o_alu_ctrl   (w_alu_funct),
    .o_funct_valid(w_funct_valid)
  );

  assign w_wait_hit = (r_wait_cnt == WAIT_LAST) && !mem_ready;
  assign state      = r_state;
  assign trap_cause = r_trap_cause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_trap_cause <= TC_NONE;
    end else begin
      r_state <= w_next;
      // Any state change clears the counter; only FETCH/MEM_RD/MEM_WR count.
      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else if ((mem_read || mem_write) && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_next == S_TRAP && r_state != S_TRAP) begin
        r_trap_cause <= w_cause;
      end
    end
  end

  // Outputs are forced low while rst is high, even though state is FETCH.
  always_comb begin
    w_next     = r_state;
    w_cause    = TC_NONE;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_source  = PCSRC_ALU;
    alu_ctrl   = ALU_AND;
    instr_done = 1'b0;
    trap       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          if (run) begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_4;
            alu_ctrl  = ALU_ADD;
            if (mem_ready) begin
              ir_write  = 1'b1;
              pc_write  = 1'b1;
              pc_source = PCSRC_ALU;
              w_next    = S_DECODE;
            end else if (w_wait_hit) begin
              w_next  = S_TRAP;
              w_cause = TC_TIMEOUT;
            end
          end
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM;
          alu_ctrl  = ALU_ADD;
          case (opcode)
            OP_RTYPE:     w_next = S_EXEC;
            OP_LW, OP_SW: w_next = S_MEM_ADDR;
            OP_BEQ, OP_BNE: w_next = S_BRANCH;
            OP_J:         w_next = S_JUMP;
            OP_ADDI:      w_next = S_IMM_EXEC;
            default: begin
              w_next  = S_TRAP;
              w_cause = TC_ILLEGAL;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_ctrl  = ALU_ADD;
          w_next    = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) begin
            w_next = S_MEM_WB;
          end else if (w_wait_hit) begin
            w_next  = S_TRAP;
            w_cause = TC_TIMEOUT;
          end
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end else if (w_wait_hit) begin
            w_next  = S_TRAP;
            w_cause = TC_TIMEOUT;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          alu_ctrl  = w_alu_funct;
          if (w_funct_valid) begin
            w_next = S_R_WB;
          end else begin
            w_next  = S_TRAP;
            w_cause = TC_ILLEGAL;
          end
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_B;
          alu_ctrl   = ALU_SUB;
          pc_source  = PCSRC_ALUOUT;
          pc_write   = zero ^ (opcode == OP_BNE);
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_IMM_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_ctrl  = ALU_ADD;
          w_next    = S_IMM_WB;
        end
        S_IMM_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: an instruction-level model expands each
// instruction into its expected per-cycle outputs, checked every cycle.
module tb_mc_control;
  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_ctrl;
    logic       instr_done, trap;
    logic [1:0] trap_cause;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    bit         run;
    bit         ready;
    bit         z;
    logic [5:0] op;
    logic [5:0] fn;
    outs_t      exp;
    bit         ign_alu;
  } cyc_t;

  logic clk = 1'b0;
  logic rst, run, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst;
  logic mem_to_reg, alu_src_a, instr_done, trap;
  logic [1:0] alu_src_b, pc_source, trap_cause;
  logic [3:0] alu_ctrl, state;

  mc_control #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_ctrl(alu_ctrl),
    .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause), .state(state)
  );

  always #5 clk = ~clk;

  outs_t act;
  assign act = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_ctrl,
                instr_done, trap, trap_cause, state};

  int    checks = 0;
  int    failures = 0;
  cyc_t  q[$];
  cyc_t  cur;
  bit    exp_valid = 0;
  string tname = "init";
  int    cyc_idx = 0;
  int    trace[$];
  int    done_trace[$];
  int    trap_cycles = 3;
  int    exp_add[4] = '{0, 1, 6, 7};
  int    exp_lw[8]  = '{0, 1, 2, 3, 3, 3, 3, 4};

  always @(negedge clk) begin : compare
    outs_t e;
    if (exp_valid) begin
      e = cur.exp;
      if (cur.ign_alu) e.alu_ctrl = act.alu_ctrl;
      checks++;
      trace.push_back(int'(act.state));
      done_trace.push_back(int'(act.instr_done));
      if (act !== e) begin
        failures++;
        $display("FAIL %s cycle=%0d outputs actual=%h required=%h (state %0d vs %0d)",
                 tname, cyc_idx, act, e, act.state, e.state);
      end
      cyc_idx++;
    end
  end

  task automatic chk(input string name, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act_v, exp_v);
    end
  endtask

  function automatic outs_t st(input int s);
    outs_t o = '0;
    o.state = 4'(s);
    return o;
  endfunction

  function automatic void push(input bit r, input bit rd, input bit z,
                               input logic [5:0] op, input logic [5:0] fn,
                               input outs_t e, input bit ign);
    cyc_t c;
    c.run = r; c.ready = rd; c.z = z; c.op = op; c.fn = fn; c.exp = e; c.ign_alu = ign;
    q.push_back(c);
  endfunction

  function automatic void ref_alu(input logic [5:0] fn, output bit v, output logic [3:0] c);
    v = 1'b1;
    case (fn)
      6'h20: c = 4'b0010;
      6'h22: c = 4'b0110;
      6'h24: c = 4'b0000;
      6'h25: c = 4'b0001;
      6'h2A: c = 4'b0111;
      6'h00: c = 4'b1000;
      default: begin v = 1'b0; c = 4'b0000; end
    endcase
  endfunction

  function automatic void add_trap(input logic [1:0] cause, input logic [5:0] op, input logic [5:0] fn);
    outs_t o = st(12);
    o.trap = 1'b1;
    o.trap_cause = cause;
    for (int i = 0; i < trap_cycles; i++) push(1'b1, bit'(i % 2), 1'b0, op, fn, o, 1'b0);
  endfunction

  // Expand one instruction into expected cycles; f_lows/m_lows are the number
  // of not-ready cycles before memory answers (>= WAIT_MAX means never).
  function automatic void add_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                                    input int f_lows, input int m_lows, input bit run_mid);
    outs_t o;
    bit v;
    logic [3:0] c;
    o = st(0); o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 4'b0010;
    for (int i = 0; i < f_lows && i < WAIT_MAX; i++) push(1, 0, z, op, fn, o, 0);
    if (f_lows >= WAIT_MAX) begin add_trap(2'b10, op, fn); return; end
    o.ir_write = 1; o.pc_write = 1;
    push(1, 1, z, op, fn, o, 0);
    o = st(1); o.alu_src_b = 2'b10; o.alu_ctrl = 4'b0010;
    push(run_mid, 1, z, op, fn, o, 0);
    case (op)
      6'h00: begin
        ref_alu(fn, v, c);
        o = st(6); o.alu_src_a = 1; o.alu_ctrl = c;
        push(run_mid, 1, z, op, fn, o, !v);
        if (!v) add_trap(2'b01, op, fn);
        else begin
          o = st(7); o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1;
          push(run_mid, 1, z, op, fn, o, 0);
        end
      end
      6'h23, 6'h2B: begin
        o = st(2); o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 4'b0010;
        push(run_mid, 1, z, op, fn, o, 0);
        o = st(op == 6'h23 ? 3 : 5); o.i_or_d = 1;
        if (op == 6'h23) o.mem_read = 1; else o.mem_write = 1;
        for (int i = 0; i < m_lows && i < WAIT_MAX; i++) push(run_mid, 0, z, op, fn, o, 0);
        if (m_lows >= WAIT_MAX) begin add_trap(2'b10, op, fn); return; end
        if (op == 6'h2B) begin
          o.instr_done = 1;
          push(run_mid, 1, z, op, fn, o, 0);
        end else begin
          push(run_mid, 1, z, op, fn, o, 0);
          o = st(4); o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1;
          push(run_mid, 1, z, op, fn, o, 0);
        end
      end
      6'h04, 6'h05: begin
        o = st(8); o.alu_src_a = 1; o.alu_ctrl = 4'b0110; o.pc_source = 2'b01;
        o.pc_write = (op == 6'h04) ? z : !z; o.instr_done = 1;
        push(run_mid, 1, z, op, fn, o, 0);
      end
      6'h02: begin
        o = st(9); o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1;
        push(run_mid, 1, z, op, fn, o, 0);
      end
      6'h08: begin
        o = st(10); o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 4'b0010;
        push(run_mid, 1, z, op, fn, o, 0);
        o = st(11); o.reg_write = 1; o.instr_done = 1;
        push(run_mid, 1, z, op, fn, o, 0);
      end
      default: add_trap(2'b01, op, fn);
    endcase
  endfunction

  // Entered and left at 1 time unit after a rising edge.
  task automatic drive_all(input string name);
    tname = name;
    cyc_idx = 0;
    trace.delete();
    done_trace.delete();
    while (q.size() > 0) begin
      cur = q.pop_front();
      run = cur.run; mem_ready = cur.ready; zero = cur.z; opcode = cur.op; funct = cur.fn;
      exp_valid = 1;
      @(posedge clk); #1;
    end
    exp_valid = 0;
  endtask

  task automatic do_reset(input string name);
    run = 1; mem_ready = 0;
    rst = 1;
    #2;
    chk({name, "_state"}, int'(state), 0);
    chk({name, "_trap"}, int'(trap), 0);
    chk({name, "_cause"}, int'(trap_cause), 0);
    chk({name, "_memrd"}, int'(mem_read), 0);
    run = 0;
    rst = 0;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    outs_t o;
    logic [5:0] fns[5] = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    int n5;
    rst = 1; run = 1; zero = 0; mem_ready = 1; opcode = 6'h00; funct = 6'h20;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_memrd_run1", int'(mem_read), 0);
    chk("reset_trap", int'(trap), 0);
    chk("reset_cause", int'(trap_cause), 0);
    run = 0;
    rst = 0;
    @(posedge clk); #1;

    o = st(0);
    for (int i = 0; i < 3; i++) push(0, i % 2 == 0, 0, 6'h00, 6'h20, o, 0);
    drive_all("idle");

    add_instr(6'h00, 6'h20, 0, 0, 0, 1);
    drive_all("add");
    chk("add_len", trace.size(), 4);
    for (int i = 0; i < 4; i++) chk("add_state_seq", trace[i], exp_add[i]);
    chk("add_done_c4", done_trace[3], 1);
    chk("add_done_c3", done_trace[2], 0);

    foreach (fns[i]) add_instr(6'h00, fns[i], 0, 0, 0, 1);
    drive_all("rtype_functs");

    add_instr(6'h23, 6'h00, 0, 0, 3, 1);
    drive_all("lw_wait3");
    chk("lw_wait3_len", trace.size(), 8);
    for (int i = 0; i < 8; i++) chk("lw_wait3_seq", trace[i], exp_lw[i]);

    add_instr(6'h23, 6'h11, 1, 0, 0, 0);
    drive_all("lw_fast_run0");
    chk("lw_latency", trace.size(), 5);
    add_instr(6'h2B, 6'h11, 0, 0, 0, 0);
    drive_all("sw_fast_run0");
    chk("sw_latency", trace.size(), 4);

    add_instr(6'h04, 6'h00, 1, 0, 0, 1);
    add_instr(6'h04, 6'h00, 0, 0, 0, 1);
    add_instr(6'h05, 6'h00, 1, 0, 0, 1);
    add_instr(6'h05, 6'h00, 0, 0, 0, 1);
    drive_all("branches");
    chk("branch_total_len", trace.size(), 12);

    add_instr(6'h02, 6'h00, 0, 0, 0, 1);
    drive_all("jump");
    chk("jump_latency", trace.size(), 3);
    add_instr(6'h08, 6'h00, 0, 2, 0, 1);
    drive_all("addi_fetchwait2");
    chk("addi_len", trace.size(), 6);

    add_instr(6'h23, 6'h00, 0, 0, WAIT_MAX - 1, 1);
    drive_all("lw_ready_at_limit");
    chk("lw_limit_len", trace.size(), 5 + WAIT_MAX - 1);

    add_instr(6'h00, 6'h3F, 0, 0, 0, 1);
    drive_all("bad_funct");
    do_reset("bad_funct_rst");

    trap_cycles = 20;
    add_instr(6'h3F, 6'h00, 0, 0, 0, 1);
    drive_all("bad_opcode");
    chk("bad_opcode_state_c3", trace[2], 12);
    do_reset("bad_opcode_rst");
    trap_cycles = 3;

    add_instr(6'h2B, 6'h00, 0, 0, 100, 1);
    drive_all("sw_timeout");
    n5 = 0;
    foreach (trace[i]) if (trace[i] == 5) n5++;
    chk("sw_timeout_memwr_cycles", n5, WAIT_MAX);
    chk("sw_timeout_trap_after", trace[3 + WAIT_MAX], 12);
    do_reset("sw_timeout_rst");

    add_instr(6'h23, 6'h00, 0, 0, 100, 1);
    while (q.size() > 6) void'(q.pop_back());
    drive_all("lw_then_rst");
    chk("lw_in_memrd", int'(state), 3);
    do_reset("lw_midwait_rst");
    add_instr(6'h00, 6'h20, 0, 0, 0, 1);
    drive_all("add_after_rst");
    chk("add_after_rst_len", trace.size(), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
